// File: rtl/dsp_pkg.sv
// Shared DSP definitions for the modulator-side and decimator-side blocks.
// Holds the CIC order, the output sample width and the saturating
// narrowing helper used to produce OUT_W-bit samples.
package dsp_pkg;

  localparam int unsigned CIC_ORDER = 3;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned SAT_IN_W  = 32;

  // Clamp a wide signed value into the signed OUT_W-bit range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SAT_IN_W-1:0] x);
    logic signed [OUT_W-1:0] r;
    if (x > 32'sd32767) begin
      r = 16'sh7fff;
    end else if (x < -32'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = x[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comb.sv
// Single CIC comb stage, differential delay 1, W-bit modulo arithmetic.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the stage (one decimated sample present on din)
//   din        : stage input
//   dout       : registered din - previous din
module cic_comb #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] dly;

  // Delay element and difference both move only when a sample is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly  <= '0;
      dout <= '0;
    end else if (en) begin
      dly  <= din;
      dout <= din - dly;
    end
  end

endmodule

// File: rtl/dsadc_decim.sv
// 3rd-order CIC decimator for a 1-bit delta-sigma bitstream.
// Integrators run at the input rate (qualified by en); every R consumed bits
// the third integrator is captured and pushed through three pipelined comb
// stages, then scaled, saturated and registered as a 16-bit sample.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : input-sample qualifier, one bit consumed per en=1 cycle
//   bitstream  : 1 -> +1, 0 -> -1
//   signal     : signed 16-bit decimated sample, held between updates
//   valid      : one-cycle pulse when signal updates
// R must be one of 32, 64, 128, 256.
module dsadc_decim
  import dsp_pkg::*;
#(
  parameter int unsigned R = 64,
  parameter int unsigned W = 2 + 3 * $clog2(R)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        bitstream,
  output logic [15:0] signal,
  output logic        valid
);

  localparam int unsigned CW = $clog2(R);
  // Full-scale CIC gain is R^3 = 2^(3*CW); shift down to a 2^15 full scale.
  localparam int unsigned SH = CIC_ORDER * CW - (OUT_W - 1);

  logic [W-1:0]          x;
  logic [W-1:0]          i1, i2, i3;
  logic [W-1:0]          i1_n, i2_n, i3_n;
  logic [CW-1:0]         cnt;
  logic                  strobe;
  logic [W-1:0]          cap;
  logic [W-1:0]          c1, c2, c3;
  logic [3:0]            pv;
  logic [1:0]            warm;
  logic signed [W-1:0]   scaled;

  // Input mapping, integrator next-state chain and decimation strobe.
  always_comb begin
    x      = bitstream ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
    i1_n   = i1 + x;
    i2_n   = i2 + i1_n;
    i3_n   = i3 + i2_n;
    strobe = en && (cnt == CW'(R - 1));
    scaled = $signed(c3) >>> SH;
  end

  // Integrators and decimation counter advance only on qualified input bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      cnt <= '0;
    end else if (en) begin
      i1  <= i1_n;
      i2  <= i2_n;
      i3  <= i3_n;
      cnt <= strobe ? '0 : cnt + CW'(1);
    end
  end

  // Capture stage plus per-stage occupancy; runs regardless of en so the
  // result lands on the output register exactly 4 clocks after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap <= '0;
      pv  <= '0;
    end else begin
      pv <= {pv[2:0], strobe};
      if (strobe) begin
        cap <= i3_n;
      end
    end
  end

  cic_comb #(.W(W)) u_comb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pv[0]),
    .din   (cap),
    .dout  (c1)
  );

  cic_comb #(.W(W)) u_comb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pv[1]),
    .din   (c1),
    .dout  (c2)
  );

  cic_comb #(.W(W)) u_comb3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pv[2]),
    .din   (c2),
    .dout  (c3)
  );

  // Output register; the first three results only fill the comb delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal <= '0;
      valid  <= 1'b0;
      warm   <= '0;
    end else begin
      valid <= 1'b0;
      if (pv[3]) begin
        if (warm == 2'd3) begin
          signal <= sat_out(SAT_IN_W'(scaled));
          valid  <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsadc_decim.sv
// Directed bench for dsadc_decim (R=64): table of bit patterns with expected
// steady outputs and valid timing, plus async reset sequences.
module tb_dsadc_decim;

  localparam int unsigned R = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        bitstream;
  logic [15:0] signal;
  logic        valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsadc_decim #(.R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bitstream (bitstream),
    .signal    (signal),
    .valid     (valid)
  );

  typedef struct {
    string                name;
    logic [7:0]           pat;
    int                   plen;
    bit                   toggle;
    logic signed [15:0]   exp_sig;
    int                   exp_first;
    int                   exp_period;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Leaves the bench at a falling edge with reset just released; the caller
  // then sets inputs for rising edge number 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    en        = 1'b0;
    bitstream = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int                 en_cnt;
    int                 nval;
    int                 last_edge;
    int                 max_c;
    logic signed [15:0] last_sig;
    bit                 hold_ok;
    en_cnt    = 0;
    nval      = 0;
    last_edge = 0;
    last_sig  = '0;
    hold_ok   = 1'b1;
    max_c     = v.exp_first + 3 * v.exp_period + 16;
    do_reset();
    for (int c = 1; c <= max_c && nval < 4; c++) begin
      en        = v.toggle ? 1'(c % 2) : 1'b1;
      bitstream = v.pat[3'(en_cnt % v.plen)];
      if (en) en_cnt++;
      @(negedge clk);
      if (valid) begin
        nval++;
        if (nval == 1) chk({v.name, " first valid edge"}, c, v.exp_first);
        else chk({v.name, " valid period"}, c - last_edge, v.exp_period);
        chk({v.name, " value"}, $signed(signal), v.exp_sig);
        last_edge = c;
        last_sig  = signal;
      end else if (nval > 0 && signal !== last_sig) begin
        hold_ok = 1'b0;
      end
    end
    chk({v.name, " valid count"}, nval, 4);
    chk({v.name, " hold between valids"}, hold_ok, 1);
  endtask

  // Reset two clocks after a post-warm-up strobe: outputs clear at once, the
  // in-flight sample is dropped and a full warm-up is needed again.
  task automatic reset_midpipe();
    int nv;
    int first;
    int early;
    nv    = 0;
    first = 0;
    early = 0;
    do_reset();
    en        = 1'b1;
    bitstream = 1'b1;
    for (int c = 1; c <= 5 * R + 2; c++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("midreset pre valid count", nv, 1);
    chk("midreset pre signal", $signed(signal), 32767);
    #2 rst_n = 1'b0;
    #1;
    chk("async clear signal", signal, 0);
    chk("async clear valid", valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 4 * R + 30; c++) begin
      @(negedge clk);
      if (valid) begin
        if (c <= 4) early++;
        if (first == 0) first = c;
      end
    end
    chk("midreset valid within 4 clk", early, 0);
    chk("midreset first new valid edge", first, 4 * R + 4);
    chk("midreset new value", $signed(signal), 32767);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ones",      8'h01, 1, 1'b0, 16'sh7fff, 4 * R + 4,     R};
    vecs[1] = '{"zeros",     8'h00, 1, 1'b0, 16'sh8000, 4 * R + 4,     R};
    vecs[2] = '{"p1110",     8'h07, 4, 1'b0, 16'sh4000, 4 * R + 4,     R};
    vecs[3] = '{"p10",       8'h01, 2, 1'b0, 16'sh0000, 4 * R + 4,     R};
    vecs[4] = '{"ones_entog", 8'h01, 1, 1'b1, 16'sh7fff, 8 * R + 3, 2 * R};

    rst_n     = 1'b1;
    en        = 1'b0;
    bitstream = 1'b0;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset signal", signal, 0);
    chk("reset valid", valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
    end

    reset_midpipe();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
